// File: rtl/mpu_load_arbiter_pkg.sv
// Shared types and matrix geometry for the MPU load arbiter.
// Also holds the dimension check used by both the arbiter and the load unit.
package mpu_load_arbiter_pkg;

    localparam int M               = 4;
    localparam int N               = 4;
    localparam int MBITS           = $clog2(M);
    localparam int NBITS           = $clog2(N);
    localparam int FP              = 32;
    localparam int MATRIX_REG_SIZE = 3;
    localparam int TOT_W           = MBITS + NBITS + 2;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_STREAM,
        ARB_DONE
    } arb_state_t;

    function automatic logic dims_ok(
        input logic [MBITS:0] m,
        input logic [NBITS:0] n
    );
        return (m != '0) && (n != '0)
            && (m <= (MBITS+1)'(M))
            && (n <= (NBITS+1)'(N));
    endfunction

endpackage

// File: rtl/mpu_load_arbiter_if.sv
// Requester-side and load-unit-side signals of the load arbiter.
// slave is the arbiter's view; master is the surrounding MPU's view.
interface mpu_load_arbiter_if
    import mpu_load_arbiter_pkg::*;
#(
    parameter int NREQ = 2
);

    logic [NREQ-1:0]                      req_in;
    logic [NREQ-1:0][MBITS:0]             req_m_size_in;
    logic [NREQ-1:0][NBITS:0]             req_n_size_in;
    logic [NREQ-1:0][MATRIX_REG_SIZE-1:0] req_addr_in;
    logic [NREQ-1:0][FP-1:0]              req_element_in;
    logic [NREQ-1:0]                      req_grant_out;
    logic [NREQ-1:0]                      req_elem_ack_out;
    logic [NREQ-1:0]                      req_done_out;
    logic [NREQ-1:0]                      req_error_out;

    logic                       load_en_out;
    logic [MBITS:0]             load_m_size_out;
    logic [NBITS:0]             load_n_size_out;
    logic [MATRIX_REG_SIZE-1:0] load_addr_out;
    logic [FP-1:0]              load_element_out;
    logic                       load_ack_in;
    logic                       load_error_in;

    modport slave (
        input  req_in, req_m_size_in, req_n_size_in,
        input  req_addr_in, req_element_in,
        input  load_ack_in, load_error_in,
        output req_grant_out, req_elem_ack_out,
        output req_done_out, req_error_out,
        output load_en_out, load_m_size_out,
        output load_n_size_out, load_addr_out,
        output load_element_out
    );

    modport master (
        output req_in, req_m_size_in, req_n_size_in,
        output req_addr_in, req_element_in,
        output load_ack_in, load_error_in,
        input  req_grant_out, req_elem_ack_out,
        input  req_done_out, req_error_out,
        input  load_en_out, load_m_size_out,
        input  load_n_size_out, load_addr_out,
        input  load_element_out
    );

endinterface

// File: rtl/mpu_rr_picker.sv
// Round-robin priority encoder: first set request at or above i_ptr,
// wrapping around. Purely combinational.
module mpu_rr_picker #(
    parameter int NREQ   = 2,
    parameter int RRBITS = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]   i_req,
    input  logic [RRBITS-1:0] i_ptr,
    output logic              o_valid,
    output logic [RRBITS-1:0] o_idx
);

    always_comb begin
        logic [RRBITS-1:0] w_j;
        o_valid = 1'b0;
        o_idx   = '0;
        w_j     = '0;
        // scan downward so the nearest requester to i_ptr wins last
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = RRBITS'((int'(i_ptr) + k) % NREQ);
            if (i_req[w_j]) begin
                o_valid = 1'b1;
                o_idx   = w_j;
            end
        end
    end

endmodule

// File: rtl/mpu_load_arbiter.sv
// Round-robin arbiter sharing the matrix load unit between NREQ
// requesters; the grant is held for one full matrix transfer.
module mpu_load_arbiter
    import mpu_load_arbiter_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int RRBITS = $clog2(NREQ)
) (
    input  logic          clk,
    input  logic          rst,
    mpu_load_arbiter_if.slave bus
);

    arb_state_t                 r_state, w_state_nxt;
    logic [RRBITS-1:0]          r_ptr, w_ptr_nxt;
    logic [RRBITS-1:0]          r_idx, w_idx_nxt;
    logic [TOT_W-1:0]           r_cnt, w_cnt_nxt;
    logic [TOT_W-1:0]           r_total, w_total_nxt;
    logic [NREQ-1:0]            r_grant, w_grant_nxt;
    logic [NREQ-1:0]            r_done, w_done_nxt;
    logic [NREQ-1:0]            r_err, w_err_nxt;
    logic                       r_en, w_en_nxt;
    logic [MBITS:0]             r_m, w_m_nxt;
    logic [NBITS:0]             r_n, w_n_nxt;
    logic [MATRIX_REG_SIZE-1:0] r_addr, w_addr_nxt;

    logic                       w_pick_vld;
    logic [RRBITS-1:0]          w_pick_idx;
    logic                       w_pick_ok;
    logic                       w_last;
    logic [NREQ-1:0]            w_elem_ack;
    logic [FP-1:0]              w_elem;

    function automatic logic [RRBITS-1:0] ptr_inc(
        input logic [RRBITS-1:0] p
    );
        return (p == RRBITS'(NREQ - 1)) ? '0 : p + RRBITS'(1);
    endfunction

    mpu_rr_picker #(
        .NREQ   (NREQ),
        .RRBITS (RRBITS)
    ) u_picker (
        .i_req   (bus.req_in),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    assign w_pick_ok = w_pick_vld && dims_ok(
        bus.req_m_size_in[w_pick_idx],
        bus.req_n_size_in[w_pick_idx]);

    assign w_last = (r_cnt == r_total - TOT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_total <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_en    <= 1'b0;
            r_m     <= '0;
            r_n     <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_total <= w_total_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_en    <= w_en_nxt;
            r_m     <= w_m_nxt;
            r_n     <= w_n_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ARB_IDLE:
                if (w_pick_ok) w_state_nxt = ARB_REQ;
            ARB_REQ:
                if (bus.load_error_in)    w_state_nxt = ARB_IDLE;
                else if (bus.load_ack_in) w_state_nxt = ARB_STREAM;
            ARB_STREAM:
                if (w_last)                w_state_nxt = ARB_DONE;
                else if (!bus.load_ack_in) w_state_nxt = ARB_IDLE;
            ARB_DONE:
                w_state_nxt = ARB_IDLE;
            default:
                w_state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        w_ptr_nxt   = r_ptr;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_total_nxt = r_total;
        w_grant_nxt = r_grant;
        w_done_nxt  = '0;
        w_err_nxt   = '0;
        w_en_nxt    = r_en;
        w_m_nxt     = r_m;
        w_n_nxt     = r_n;
        w_addr_nxt  = r_addr;
        w_elem_ack  = '0;
        w_elem      = '0;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_pick_ok) begin
                    w_idx_nxt               = w_pick_idx;
                    w_grant_nxt             = '0;
                    w_grant_nxt[w_pick_idx] = 1'b1;
                    w_en_nxt                = 1'b1;
                    w_m_nxt    = bus.req_m_size_in[w_pick_idx];
                    w_n_nxt    = bus.req_n_size_in[w_pick_idx];
                    w_addr_nxt = bus.req_addr_in[w_pick_idx];
                end else if (w_pick_vld) begin
                    // bad dimensions: reject without bothering the load unit
                    w_err_nxt[w_pick_idx] = 1'b1;
                    w_ptr_nxt = ptr_inc(w_pick_idx);
                end
            end
            ARB_REQ: begin
                if (bus.load_error_in) begin
                    w_err_nxt[r_idx] = 1'b1;
                    w_grant_nxt      = '0;
                    w_en_nxt         = 1'b0;
                    w_ptr_nxt        = ptr_inc(r_idx);
                end else if (bus.load_ack_in) begin
                    w_en_nxt    = 1'b0;
                    w_cnt_nxt   = '0;
                    w_total_nxt = TOT_W'(r_m) * TOT_W'(r_n);
                end
            end
            ARB_STREAM: begin
                w_elem_ack[r_idx] = 1'b1;
                w_elem            = bus.req_element_in[r_idx];
                w_cnt_nxt         = r_cnt + TOT_W'(1);
                if (w_last) begin
                    w_done_nxt[r_idx] = 1'b1;
                    w_grant_nxt       = '0;
                end else if (!bus.load_ack_in) begin
                    w_err_nxt[r_idx] = 1'b1;
                    w_grant_nxt      = '0;
                    w_ptr_nxt        = ptr_inc(r_idx);
                end
            end
            ARB_DONE: begin
                w_ptr_nxt = ptr_inc(r_idx);
            end
            default: begin
                w_grant_nxt = '0;
            end
        endcase
    end

    assign bus.req_grant_out    = r_grant;
    assign bus.req_elem_ack_out = w_elem_ack;
    assign bus.req_done_out     = r_done;
    assign bus.req_error_out    = r_err;
    assign bus.load_en_out      = r_en;
    assign bus.load_m_size_out  = r_m;
    assign bus.load_n_size_out  = r_n;
    assign bus.load_addr_out    = r_addr;
    assign bus.load_element_out = w_elem;

endmodule

// File: tb/tb_mpu_load_arbiter.sv
// Directed bench for mpu_load_arbiter: the bench plays both requesters
// and the load unit, cycle by cycle.
module tb_mpu_load_arbiter;
    import mpu_load_arbiter_pkg::*;

    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mpu_load_arbiter_if #(.NREQ(NR)) bus ();

    mpu_load_arbiter #(.NREQ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [FP-1:0] fv [6] = '{
        32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
        32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000
    };

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int m,
                           input int n, input int a);
        bus.req_m_size_in[i] = (MBITS+1)'(m);
        bus.req_n_size_in[i] = (NBITS+1)'(n);
        bus.req_addr_in[i]   = MATRIX_REG_SIZE'(a);
        bus.req_in[i]        = 1'b1;
    endtask

    // grant cycle, then load unit acks; returns in the first stream cycle
    task automatic start(input int i, input int m,
                         input int n, input int a);
        tick();
        chk("gnt", 64'(bus.req_grant_out), 64'(1 << i));
        chk("en", 64'(bus.load_en_out), 64'd1);
        chk("m", 64'(bus.load_m_size_out), 64'(m));
        chk("n", 64'(bus.load_n_size_out), 64'(n));
        chk("addr", 64'(bus.load_addr_out), 64'(a));
        bus.load_ack_in = 1'b1;
        tick();
        chk("en_off", 64'(bus.load_en_out), 64'd0);
    endtask

    task automatic stream(input int i, input int cnt, input bit use_fv);
        logic [FP-1:0] v;
        for (int k = 0; k < cnt; k++) begin
            v = use_fv ? fv[k] : FP'(100 + k);
            bus.req_element_in[i] = v;
            bus.load_ack_in = (k != cnt - 1);
            #1;
            chk("eack", 64'(bus.req_elem_ack_out), 64'(1 << i));
            chk("elem", 64'(bus.load_element_out), 64'(v));
            tick();
        end
        bus.load_ack_in = 1'b0;
        #1;
        chk("done", 64'(bus.req_done_out), 64'(1 << i));
        chk("dn_err", 64'(bus.req_error_out), 64'd0);
        chk("dn_gnt", 64'(bus.req_grant_out), 64'd0);
        chk("dn_eack", 64'(bus.req_elem_ack_out), 64'd0);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_gnt"}, 64'(bus.req_grant_out), 64'd0);
        chk({tag, "_eack"}, 64'(bus.req_elem_ack_out), 64'd0);
        chk({tag, "_done"}, 64'(bus.req_done_out), 64'd0);
        chk({tag, "_err"}, 64'(bus.req_error_out), 64'd0);
        chk({tag, "_en"}, 64'(bus.load_en_out), 64'd0);
        chk({tag, "_m"}, 64'(bus.load_m_size_out), 64'd0);
        chk({tag, "_n"}, 64'(bus.load_n_size_out), 64'd0);
        chk({tag, "_addr"}, 64'(bus.load_addr_out), 64'd0);
        chk({tag, "_elem"}, 64'(bus.load_element_out), 64'd0);
    endtask

    initial begin
        bus.req_in         = '0;
        bus.req_m_size_in  = '0;
        bus.req_n_size_in  = '0;
        bus.req_addr_in    = '0;
        bus.req_element_in = '0;
        bus.load_ack_in    = 1'b0;
        bus.load_error_in  = 1'b0;
        #3;
        all_zero("rst");
        @(negedge clk);
        rst = 1'b1;
        tick();

        // single requester, 2x3 into register 1
        set_req(0, 2, 3, 1);
        start(0, 2, 3, 1);
        stream(0, 6, 1'b1);
        bus.req_in = '0;
        tick();
        chk("t1_idle_done", 64'(bus.req_done_out), 64'd0);

        // simultaneous pair from pointer 0
        rst = 1'b0;
        #1;
        rst = 1'b1;
        set_req(0, 1, 1, 2);
        set_req(1, 1, 2, 3);
        start(0, 1, 1, 2);
        stream(0, 1, 1'b0);
        tick();
        chk("gap_gnt", 64'(bus.req_grant_out), 64'd0);
        start(1, 1, 2, 3);
        stream(1, 2, 1'b0);
        tick();
        start(0, 1, 1, 2);
        stream(0, 1, 1'b0);
        bus.req_in = '0;
        tick();

        // req1 with n=0 rejected while req0 also waits
        set_req(0, 1, 1, 4);
        set_req(1, 1, 0, 5);
        tick();
        chk("rej_err", 64'(bus.req_error_out), 64'b10);
        chk("rej_gnt", 64'(bus.req_grant_out), 64'd0);
        chk("rej_en", 64'(bus.load_en_out), 64'd0);
        bus.req_in[1] = 1'b0;
        start(0, 1, 1, 4);
        chk("rej_err_clr", 64'(bus.req_error_out), 64'd0);
        stream(0, 1, 1'b0);
        bus.req_in = '0;
        tick();

        // load unit refuses a full-size request
        set_req(0, M, N, 6);
        tick();
        chk("le_gnt", 64'(bus.req_grant_out), 64'b01);
        bus.load_error_in = 1'b1;
        tick();
        chk("le_err", 64'(bus.req_error_out), 64'b01);
        chk("le_gnt0", 64'(bus.req_grant_out), 64'd0);
        chk("le_en0", 64'(bus.load_en_out), 64'd0);
        bus.load_error_in = 1'b0;
        set_req(0, 1, 1, 0);
        set_req(1, 1, 1, 7);
        start(1, 1, 1, 7);
        stream(1, 1, 1'b0);
        bus.req_in = '0;
        tick();

        // full-size matrix
        set_req(0, M, N, 2);
        start(0, M, N, 2);
        stream(0, M * N, 1'b0);
        bus.req_in = '0;
        tick();

        // reset in the middle of a transfer, then restart from element 0
        set_req(0, 2, 3, 1);
        start(0, 2, 3, 1);
        for (int k = 0; k < 3; k++) begin
            bus.req_element_in[0] = fv[k];
            bus.load_ack_in = 1'b1;
            #1;
            chk("pre_eack", 64'(bus.req_elem_ack_out), 64'b01);
            tick();
        end
        bus.req_element_in[0] = fv[3];
        rst = 1'b0;
        #1;
        all_zero("mid");
        bus.load_ack_in = 1'b0;
        rst = 1'b1;
        start(0, 2, 3, 1);
        stream(0, 6, 1'b1);
        bus.req_in = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpu_load_arbiter.md
Name: mpu_load_arbiter

Overview:
- Shares the single matrix load unit (external source -> register file) between NREQ independent load requesters, e.g. a host stream and a DMA stream.
- Round-robin arbitration; the grant is held for one complete matrix transfer.
- Forwards the granted requester's dimensions, address and element stream to the load unit, and returns per-element accept strobes, done and error status to that requester.
- Sits between the requesters and the load unit inside the MPU.

Parameters:
- NREQ, 2, number of requesters (2..8)
- RRBITS, $clog2(NREQ), width of the grant index / priority pointer

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_in  in  NREQ  per-requester load request (level; held until done or error)
- req_m_size_in  in  NREQ x (MBITS+1)  requested rows
- req_n_size_in  in  NREQ x (NBITS+1)  requested columns
- req_addr_in  in  NREQ x MATRIX_REG_SIZE  destination matrix register
- req_element_in  in  NREQ x FP  element stream, row-major, one per cycle while granted
- req_grant_out  out  NREQ  one-hot grant
- req_elem_ack_out  out  NREQ  element consumed this cycle; requester advances its stream
- req_done_out  out  NREQ  1-cycle pulse: matrix fully loaded
- req_error_out  out  NREQ  1-cycle pulse: load rejected or aborted
- load_en_out  out  1  to load unit: start request
- load_m_size_out  out  MBITS+1  to load unit
- load_n_size_out  out  NBITS+1  to load unit
- load_addr_out  out  MATRIX_REG_SIZE  to load unit
- load_element_out  out  FP  to load unit
- load_ack_in  in  1  from load unit: accepted / streaming
- load_error_in  in  1  from load unit: dimension error

Behaviour:
- Reset (rst=0, asynchronous): state ARB_IDLE; rr_ptr=0; elem_cnt=0; all outputs 0, including sizes, address and element.
- All outputs are registered, except load_element_out and req_elem_ack_out, which are combinational from the granted index and state.
- ARB_IDLE:
  - Choose the first asserted req_in[i], searching from rr_ptr upward with wrap-around.
  - Next cycle: register grant_idx, assert req_grant_out[grant_idx], latch m, n and addr into load_*_out, go to ARB_REQ.
  - No request: stay in ARB_IDLE.
  - Arbiter-side dimension check is the same as the load unit's: m=0, n=0, m>M or n>N are rejected.
    - In that case, pulse req_error_out[i] and do not grant.
    - Advance rr_ptr to i+1, stay in ARB_IDLE.
- ARB_REQ:
  - load_en_out=1.
  - load_error_in=1: pulse error, drop grant, rr_ptr=grant_idx+1, go to ARB_IDLE.
  - load_ack_in=1: load_en_out=0; total = m*n, computed at width MBITS+NBITS+2; elem_cnt=0; go to ARB_STREAM.
  - Neither: wait indefinitely.
- ARB_STREAM:
  - Each cycle: load_element_out = req_element_in[grant_idx]; req_elem_ack_out[grant_idx]=1; elem_cnt++.
  - When elem_cnt == total-1, this is the last element: go to ARB_DONE.
  - load_ack_in=0 on a non-final element cycle means an abort: pulse error, release, go to ARB_IDLE.
  - load_ack_in is ignored on the final cycle, because the load unit drops it there.
- ARB_DONE:
  - Pulse req_done_out[grant_idx] for one cycle.
  - Drop grant; rr_ptr = grant_idx+1 mod NREQ; go to ARB_IDLE.
  - Back-to-back grants therefore have at least 1 idle cycle between them.
- Requester deasserting req_in while granted: ignored; the transfer completes. The load unit has no cancel.
- Simultaneous requests: strict round-robin from rr_ptr; no requester is granted twice while another is waiting.
- Sizes, address and grant_idx are frozen from ARB_REQ until release; req_*_in changes during a transfer have no effect, except req_element_in.
- Latency: req_in -> grant is 1 cycle; grant -> first element accept is at least 2 cycles. Throughput is 1 element/cycle.
- Reset mid-transfer: immediate return to reset state. The load unit is reset by the same system reset.

Decomposition:
- mpu_pkg gains the typedef enum arb_state_t {ARB_IDLE, ARB_REQ, ARB_STREAM, ARB_DONE}.
- M, N, FP, MBITS, NBITS and MATRIX_REG_SIZE continue to come from global_defs.
- One natural sub-module: mpu_rr_picker.
  - Combinational round-robin priority encoder: req vector + rr_ptr -> valid + index.
  - Reusable for a future store arbiter.

Test Plan:
- Single requester, req0 with m=2, n=3, addr=1, elements 1.0..6.0 -> grant0 after 1 cycle; load_en 1 until ack; 6 consecutive elem_ack0 with load_element_out 1.0..6.0 in order; done0 pulse; grant released.
- Both request in the same cycle with rr_ptr=0 -> req0 served to done, 1 idle cycle, then req1 granted; next simultaneous pair is served req0 first again (pointer rotation verified).
- req1 with n=0 -> error1 pulse in 1 cycle, no grant, load_en never asserted; req0 unaffected.
- Load unit asserts load_error_in in ARB_REQ (m=M, n=N, error forced) -> error0 pulse, grant dropped, state ARB_IDLE, rr_ptr=1.
- m=M, n=N full-size matrix -> exactly M*N elem_acks, last element accepted while load_ack_in=0, done pulse, no spurious error.
- rst low at element 3 of 6 -> all outputs 0 immediately, same cycle; after rst=1 the held req0 is regranted and restarts from element 0.
